data_ram_ctrl: RTL and testbench

- Parametrised, handshaked data memory for the npc core's load/store path.
- Accepts one load or store request at a time on a valid/ready request channel and returns the result on a valid/ready response channel after a programmable latency.
- Handles byte/half/word/dword access, sign or zero extension, byte-lane write masking, and misalignment and out-of-range error reporting.
- Sits between the LSU and physical memory.

---
 rtl/data_ram_ctrl.sv | 134 +++++++++++++
 tb/tb_data_ram_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_ctrl.sv
// Handshaked load/store data memory for the npc LSU: byte/half/word/dword access,
// sign/zero extension, byte-lane masking and error reporting.
module data_ram_ctrl #(
  parameter int          DATA_WIDTH = 64,
  parameter int          DEPTH_LOG2 = 13,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int          LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [63:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                state;
  logic [3:0]            lat_cnt;
  logic                  accept;
  logic [63:0]           off;
  logic [DEPTH_LOG2-1:0] index;
  logic [2:0]            lane;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic [7:0]            byte_mask;
  logic [63:0]           wdata_sh;

  assign accept = req_valid && req_ready;
  assign off    = req_addr - BASE_ADDR;
  assign index  = off[DEPTH_LOG2+2:3];
  // BASE_ADDR is dword aligned, so the low offset bits equal req_addr[2:0].
  assign lane   = off[2:0];

  assign out_of_range = |off[63:DEPTH_LOG2+3];

  assign req_err  = misaligned || out_of_range;
  assign wdata_sh = req_wdata << {lane, 3'b000};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    misaligned = 1'b0;
    byte_mask  = 8'h00;
    unique case (req_size)
      2'b00: byte_mask = 8'h01;
      2'b01: begin misaligned = lane[0];        byte_mask = 8'h03; end
      2'b10: begin misaligned = |lane[1:0];     byte_mask = 8'h0F; end
      2'b11: begin misaligned = |lane;          byte_mask = 8'hFF; end
    endcase
    byte_mask = byte_mask << lane;
  end

  // Shift the addressed lanes down, truncate to the access size and extend.
  function automatic logic [63:0] shape_resp(input logic [63:0] raw, input logic wen,
                                             input logic err, input logic [1:0] size,
                                             input logic sgn, input logic [2:0] sh_lane);
    logic [63:0] sh;
    sh = raw >> {sh_lane, 3'b000};
    if (wen || err) return 64'h0;
    case (size)
      2'b00:   return {{56{sgn & sh[7]}},  sh[7:0]};
      2'b01:   return {{48{sgn & sh[15]}}, sh[15:0]};
      2'b10:   return {{32{sgn & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  logic [63:0] mem [2**DEPTH_LOG2];

  // NOTE: the array has no reset; contents survive rst_n and only masked lanes are written.
  always_ff @(posedge clk) begin
    if (accept && req_wen && !req_err) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_mask[b]) mem[index][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_ready  <= 1'b0;
            resp_err   <= req_err;
            resp_rdata <= shape_resp(mem[index], req_wen, req_err, req_size, req_signed, lane);
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_M1;
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: one instance at LATENCY=1 (slot 0), one at LATENCY=4 (slot 1).
module tb_data_ram_ctrl;

  localparam logic [63:0] BASE = 64'h8000_0000;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen   [2];
  logic [63:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [1:0]  req_size  [2];
  logic        req_signed[2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [63:0] resp_rdata[2];
  logic        resp_err  [2];

  int          lat_of [2] = '{1, 4};
  exp_t        sb [$];
  logic [7:0]  model_mem [longint unsigned];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_ram_ctrl #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_size(req_size[0]),
    .req_signed(req_signed[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_ram_ctrl #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_size(req_size[1]),
    .req_signed(req_signed[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-granular reference memory; each slot keeps its own address space.
  function automatic void model_req(input int d, input logic wen, input logic [63:0] addr,
                                    input logic [63:0] wdata, input logic [1:0] size,
                                    input logic sgn, output exp_t e);
    logic [63:0]     offs;
    longint unsigned key;
    int              n;
    offs    = addr - BASE;
    n       = 1 << size;
    e.rdata = 64'h0;
    e.err   = (offs >= 64'h1_0000) || ((addr % 64'(n)) != 64'h0);
    if (e.err) return;
    for (int i = 0; i < n; i++) begin
      key = (longint'(d) << 40) + offs + 64'(i);
      if (wen) model_mem[key] = wdata[8*i +: 8];
      else     e.rdata[8*i +: 8] = model_mem.exists(key) ? model_mem[key] : 8'h00;
    end
    if (!wen && sgn && n < 8 && e.rdata[8*n-1])
      for (int i = n; i < 8; i++) e.rdata[8*i +: 8] = 8'hFF;
  endfunction

  task automatic do_req(input int d, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [1:0] size, input logic sgn,
                        input int stall, input string tag);
    exp_t        e;
    logic [63:0] got_rdata;
    logic        got_err;
    int          n;
    int          lat;
    model_req(d, wen, addr, wdata, size, sgn, e);
    sb.push_back(e);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_wen[d]    = wen;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_size[d]   = size;
    req_signed[d] = sgn;
    resp_ready[d] = (stall == 0);
    n = 0;
    while (!req_ready[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " req_ready"}, 64'(req_ready[d]), 64'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_valid[d]  = 1'b0;
        req_addr[d]   = {$urandom, $urandom};
        req_wdata[d]  = {$urandom, $urandom};
        req_size[d]   = 2'($urandom);
        req_signed[d] = 1'($urandom);
      end
    end while (!resp_valid[d] && lat < 40);
    check({tag, " latency"}, 64'(lat), 64'(lat_of[d]));
    got_rdata = resp_rdata[d];
    got_err   = resp_err[d];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, " stall valid"}, 64'(resp_valid[d]), 64'd1);
      check({tag, " stall rdata"}, resp_rdata[d], got_rdata);
      check({tag, " stall err"}, 64'(resp_err[d]), 64'(got_err));
      check({tag, " stall req_ready"}, 64'(req_ready[d]), 64'd0);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    check({tag, " valid drop"}, 64'(resp_valid[d]), 64'd0);
    check({tag, " ready back"}, 64'(req_ready[d]), 64'd1);
    e = sb.pop_front();
    check({tag, " rdata"}, got_rdata, e.rdata);
    check({tag, " err"}, 64'(got_err), 64'(e.err));
  endtask

  initial begin
    exp_t dummy;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
      req_size[d]  = 2'b00; req_signed[d] = 1'b0; resp_ready[d] = 1'b1;
    end
    #22;
    for (int d = 0; d < 2; d++) begin
      check("reset req_ready", 64'(req_ready[d]), 64'd1);
      check("reset resp_valid", 64'(resp_valid[d]), 64'd0);
      check("reset resp_rdata", resp_rdata[d], 64'h0);
      check("reset resp_err", 64'(resp_err[d]), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_req(0, 1, BASE,              64'h0123_4567_89AB_CDEF, 2'b11, 0, 0, "init0");
    do_req(0, 1, BASE + 64'h10,     64'h1122_3344_5566_7788, 2'b11, 0, 0, "sd 10");
    do_req(0, 0, BASE + 64'h10,     64'h0,                   2'b11, 0, 0, "ld 10");
    do_req(0, 1, BASE + 64'h3,      64'hDEAD_BEEF_CAFE_0080, 2'b00, 0, 0, "sb 3");
    do_req(0, 0, BASE + 64'h3,      64'h0,                   2'b00, 1, 0, "lb 3");
    do_req(0, 0, BASE + 64'h3,      64'h0,                   2'b00, 0, 0, "lbu 3");
    do_req(0, 0, BASE,              64'h0,                   2'b11, 1, 0, "ld 0 lane3");
    do_req(0, 0, BASE + 64'h2,      64'h0,                   2'b10, 0, 0, "lw misalign");
    do_req(0, 1, 64'h7FFF_FFF8,     64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 0, 0, "sd below");
    do_req(0, 0, BASE,              64'h0,                   2'b11, 0, 0, "ld 0 kept");
    do_req(0, 0, BASE + 64'h1_0000, 64'h0,                   2'b11, 0, 0, "ld above");
    do_req(0, 1, BASE + 64'h1,      64'h0000_0000_0000_5555, 2'b01, 0, 0, "sh misalign");
    do_req(0, 1, BASE + 64'h6,      64'h0000_0000_0000_BEEF, 2'b01, 0, 0, "sh 6");
    do_req(0, 0, BASE,              64'h0,                   2'b11, 0, 0, "ld 0 half");
    do_req(0, 0, BASE + 64'h6,      64'h0,                   2'b01, 1, 0, "lh 6");
    do_req(0, 0, BASE + 64'h4,      64'h0,                   2'b10, 1, 0, "lw 4");
    do_req(0, 0, BASE + 64'h4,      64'h0,                   2'b10, 0, 0, "lwu 4");
    do_req(0, 0, BASE + 64'hFFF8,   64'h0,                   2'b11, 0, 0, "ld top");

    do_req(1, 1, BASE + 64'h8,      64'hA5A5_0F0F_1234_5678, 2'b11, 0, 3, "L4 sd 8");
    do_req(1, 0, BASE + 64'h8,      64'h0,                   2'b11, 0, 3, "L4 ld 8");
    do_req(1, 0, BASE + 64'hA,      64'h0,                   2'b01, 1, 0, "L4 lh a");

    // Store accepted, then asynchronous reset while the response is still pending.
    model_req(1, 1, BASE + 64'h20, 64'h0BAD_F00D_7777_1234, 2'b11, 0, dummy);
    @(negedge clk);
    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_addr[1] = BASE + 64'h20;
    req_wdata[1] = 64'h0BAD_F00D_7777_1234; req_size[1] = 2'b11; req_signed[1] = 1'b0;
    check("rst store ready", 64'(req_ready[1]), 64'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst resp_valid", 64'(resp_valid[1]), 64'd0);
    check("midrst req_ready", 64'(req_ready[1]), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1, 0, BASE + 64'h20, 64'h0, 2'b11, 0, 0, "L4 ld after rst");

    check("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
